// File: rtl/cpu_pkg.sv
// Shared load/store encodings, the load-align state encoding and a size helper.
package cpu_pkg;

  localparam logic [1:0] LS_RSVD = 2'b00;
  localparam logic [1:0] LS_WORD = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;
  localparam logic [1:0] LS_BYTE = 2'b11;

  localparam int LS_SIZE_LSB = 0;
  localparam int LS_SIZE_MSB = 1;
  localparam int LS_SIGN_BIT = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT2 = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WAIT2 = ST_WAIT2,
    S_HOLD  = ST_HOLD
  } la_state_e;

  // Field order matches the ls_ctrl bus: [2] sign, [1:0] size.
  typedef struct packed {
    logic       sign;
    logic [1:0] size;
  } ls_ctrl_t;

  // Access width in bytes; reserved encoding yields 0.
  function automatic logic [4:0] ls_bytes(input logic [1:0] size, input logic [4:0] word_bytes);
    case (size)
      LS_WORD: ls_bytes = word_bytes;
      LS_HALF: ls_bytes = 5'd2;
      LS_BYTE: ls_bytes = 5'd1;
      default: ls_bytes = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/lane_extract_ext.sv
// Combinational lane select + extend: shifts a two-word window right by the byte
// offset, keeps the low size bytes and fills the rest with zero or the field MSB.
module lane_extract_ext
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  logic [2*DATA_W-1:0] i_merged,
  input  logic [OFF_W-1:0]    i_off,
  input  logic [1:0]          i_size,
  input  logic                i_sign,
  output logic [DATA_W-1:0]   o_data
);

  localparam int NB = DATA_W / 8;

  logic [NB-1:0][7:0] w_src;
  logic [4:0]         w_nbytes;
  logic               w_msb;
  logic               w_fill;

  assign w_src    = DATA_W'(i_merged >> {i_off, 3'b000});
  assign w_nbytes = ls_bytes(i_size, 5'(NB));

  always_comb begin
    w_msb = 1'b0;
    for (int b = 0; b < NB; b++)
      if (5'(b + 1) == w_nbytes) w_msb = w_src[b][7];
  end

  // Full-width word loads never reach the fill path, so sign is a no-op there.
  assign w_fill = i_sign & w_msb;

  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign o_data[b*8 +: 8] = (5'(b) < w_nbytes) ? w_src[b] : {8{w_fill}};
  end

endmodule

// File: rtl/load_align_unit.sv
// Load alignment stage: picks the addressed byte/half/word out of the MDR, merges a
// second beat for word-crossing loads (or traps), and holds the result on valid/ready.
module load_align_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter bit ALLOW_UNALIGNED = 1'b1,
  localparam int NB             = DATA_W / 8,
  localparam int OFF_W          = $clog2(NB)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        ls_ctrl,
  input  logic [OFF_W-1:0]  addr_off,
  input  logic [DATA_W-1:0] Data_MDR,
  output logic              mem2_req,
  input  logic              mem2_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Data_out,
  output logic              misalign_exc
);

  la_state_e           r_state, w_nstate;
  ls_ctrl_t            r_ctrl;
  logic [OFF_W-1:0]    r_off;
  logic [DATA_W-1:0]   r_first;
  logic [DATA_W-1:0]   r_data;
  logic                r_exc;

  ls_ctrl_t            w_req_ctrl;
  logic [4:0]          w_req_bytes;
  logic [4:0]          w_end;
  logic                w_cross;
  logic                w_rsvd;
  logic                w_accept;
  logic                w_load_out;
  logic                w_exc;

  logic [2*DATA_W-1:0] w_merged;
  logic [OFF_W-1:0]    w_off;
  ls_ctrl_t            w_ctrl;
  logic [DATA_W-1:0]   w_ext;

  assign w_req_ctrl  = ls_ctrl_t'(ls_ctrl);
  assign w_req_bytes = ls_bytes(w_req_ctrl.size, 5'(NB));
  assign w_end       = 5'(addr_off) + w_req_bytes;
  assign w_cross     = w_end > 5'(NB);
  assign w_rsvd      = (w_req_ctrl.size == LS_RSVD);
  assign w_accept    = req_valid & req_ready;

  // One extractor serves both paths: live MDR in IDLE, latched first beat + MDR in WAIT2.
  always_comb begin
    if (r_state == S_WAIT2) begin
      w_merged = {Data_MDR, r_first};
      w_off    = r_off;
      w_ctrl   = r_ctrl;
    end else begin
      w_merged = {{DATA_W{1'b0}}, Data_MDR};
      w_off    = addr_off;
      w_ctrl   = w_req_ctrl;
    end
  end

  lane_extract_ext #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_extract_ext (
    .i_merged (w_merged),
    .i_off    (w_off),
    .i_size   (w_ctrl.size),
    .i_sign   (w_ctrl.sign),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  always_comb begin
    w_nstate   = r_state;
    w_load_out = 1'b0;
    w_exc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_rsvd || (w_cross && !ALLOW_UNALIGNED)) begin
            w_exc = 1'b1;
          end else if (w_cross) begin
            w_nstate = S_WAIT2;
          end else begin
            w_nstate   = S_HOLD;
            w_load_out = 1'b1;
          end
        end
      end
      S_WAIT2: begin
        if (mem2_valid) begin
          w_nstate   = S_HOLD;
          w_load_out = 1'b1;
        end
      end
      S_HOLD: begin
        if (out_ready) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl  <= '0;
      r_off   <= '0;
      r_first <= '0;
      r_data  <= '0;
      r_exc   <= 1'b0;
    end else begin
      r_exc <= w_exc;
      if (w_accept) begin
        r_ctrl  <= w_req_ctrl;
        r_off   <= addr_off;
        r_first <= Data_MDR;
      end
      if (w_load_out) r_data <= w_ext;
    end
  end

  assign req_ready    = (r_state == S_IDLE);
  assign mem2_req     = (r_state == S_WAIT2);
  assign out_valid    = (r_state == S_HOLD);
  assign Data_out     = r_data;
  assign misalign_exc = r_exc;

endmodule

// File: tb/tb_load_align_unit.sv
// Scoreboard bench for load_align_unit: one merging instance and one trapping instance.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic [2:0]  ls_ctrl = '0;
  logic [1:0]  addr_off = '0;
  logic [31:0] Data_MDR = '0;
  logic        mem2_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        req_ready, mem2_req, out_valid, misalign_exc;
  logic [31:0] Data_out;
  logic        req_ready0, mem2_req0, out_valid0, misalign_exc0;
  logic [31:0] Data_out0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  load_align_unit #(.DATA_W(32), .ALLOW_UNALIGNED(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .ls_ctrl(ls_ctrl), .addr_off(addr_off), .Data_MDR(Data_MDR), .mem2_req(mem2_req),
    .mem2_valid(mem2_valid), .out_valid(out_valid), .out_ready(out_ready),
    .Data_out(Data_out), .misalign_exc(misalign_exc)
  );

  load_align_unit #(.DATA_W(32), .ALLOW_UNALIGNED(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .ls_ctrl(ls_ctrl), .addr_off(addr_off), .Data_MDR(Data_MDR), .mem2_req(mem2_req0),
    .mem2_valid(mem2_valid), .out_valid(out_valid0), .out_ready(out_ready),
    .Data_out(Data_out0), .misalign_exc(misalign_exc0)
  );

  // Reference: byte array over {second, first}, little-endian lanes.
  function automatic logic [31:0] model(input logic [2:0] c, input logic [1:0] off,
                                        input logic [31:0] f, input logic [31:0] s);
    logic [7:0]  b[8];
    logic [31:0] v;
    int          n;
    for (int i = 0; i < 4; i++) begin
      b[i]     = f[8*i +: 8];
      b[i + 4] = s[8*i +: 8];
    end
    n = (c[1:0] == 2'b01) ? 4 : (c[1:0] == 2'b10) ? 2 : 1;
    v = {32{c[2] & b[int'(off) + n - 1][7]}};
    for (int i = 0; i < n; i++) v[8*i +: 8] = b[int'(off) + i];
    return v;
  endfunction

  task automatic issue(input logic [2:0] c, input logic [1:0] o, input logic [31:0] d);
    req_valid = 1'b1; ls_ctrl = c; addr_off = o; Data_MDR = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_out(output bit to);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    to = !out_valid;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (mem2_req !== 1'b0) begin failures++; $display("FAIL reset_mem2_req got=%b exp=0", mem2_req); end
    checks++; if (misalign_exc !== 1'b0) begin failures++; $display("FAIL reset_exc got=%b exp=0", misalign_exc); end
    checks++; if (Data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", Data_out); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    logic [31:0] e;
    exp_q.push_back(32'hDEADBEEF);
    issue(3'b001, 2'd0, 32'hDEADBEEF);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL word_latency out_valid=%b exp=1", out_valid); end
    e = exp_q.pop_front();
    checks++; if (Data_out !== e) begin failures++; $display("FAIL word_data got=%h exp=%h", Data_out, e); end
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL word_hold_ready got=%b exp=0", req_ready); end
    release_out();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL word_release out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_subword();
    logic [2:0]  c[5]  = '{3'b111, 3'b011, 3'b110, 3'b010, 3'b110};
    logic [1:0]  o[5]  = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] d[5]  = '{32'h80FF0000, 32'h80FF0000, 32'h80011234, 32'h80011234, 32'h0000F00D};
    logic [31:0] ex[5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00001234, 32'hFFFFF00D};
    logic [31:0] e;
    bit          to;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      issue(c[i], o[i], d[i]);
      wait_out(to);
      e = exp_q.pop_front();
      checks++;
      if (to || Data_out !== e) begin
        failures++; $display("FAIL subword_%0d got=%h exp=%h timeout=%0d", i, Data_out, e, to);
      end
      release_out();
    end
  endtask

  task automatic test_misalign();
    logic [31:0] e;
    req_valid0 = 1'b1; ls_ctrl = 3'b010; addr_off = 2'd3; Data_MDR = 32'h12345678;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    checks++; if (misalign_exc0 !== 1'b1) begin failures++; $display("FAIL misalign_pulse got=%b exp=1", misalign_exc0); end
    checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL misalign_no_out got=%b exp=0", out_valid0); end
    @(posedge clk); #1;
    checks++; if (misalign_exc0 !== 1'b0) begin failures++; $display("FAIL misalign_one_cycle got=%b exp=0", misalign_exc0); end
    checks++; if (out_valid0 !== 1'b0 || req_ready0 !== 1'b1) begin
      failures++; $display("FAIL misalign_idle out_valid=%b req_ready=%b exp=0/1", out_valid0, req_ready0);
    end
    // Non-crossing access still works on the trapping variant.
    exp_q.push_back(32'h00000080);
    req_valid0 = 1'b1; ls_ctrl = 3'b011; addr_off = 2'd3; Data_MDR = 32'h80FF0000;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    e = exp_q.pop_front();
    checks++; if (out_valid0 !== 1'b1 || Data_out0 !== e) begin
      failures++; $display("FAIL noalign_byte valid=%b got=%h exp=%h", out_valid0, Data_out0, e);
    end
    release_out();
    // Reserved size traps even when merging is allowed.
    issue(3'b100, 2'd0, 32'hAAAAAAAA);
    checks++; if (misalign_exc !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL reserved_size exc=%b out_valid=%b exp=1/0", misalign_exc, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cross();
    logic [31:0] e;
    int          cnt;
    bit          to;
    exp_q.push_back(32'h55443322);
    issue(3'b001, 2'd1, 32'h44332211);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem2_req) cnt++;
      if (i == 2) begin mem2_valid = 1'b1; Data_MDR = 32'h88776655; end
      @(posedge clk); #1;
    end
    mem2_valid = 1'b0;
    checks++; if (cnt != 3 || mem2_req !== 1'b0) begin
      failures++; $display("FAIL cross_mem2_req cycles=%0d exp=3 now=%b", cnt, mem2_req);
    end
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || Data_out !== e) begin
      failures++; $display("FAIL cross_word valid=%b got=%h exp=%h", out_valid, Data_out, e);
    end
    release_out();
    // Stray mem2_valid while idle does nothing.
    mem2_valid = 1'b1;
    @(posedge clk); #1;
    mem2_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || mem2_req !== 1'b0) begin
      failures++; $display("FAIL stray_mem2 out_valid=%b mem2_req=%b exp=0/0", out_valid, mem2_req);
    end
    exp_q.push_back(32'hFFFFC4AA);
    issue(3'b110, 2'd3, 32'hAABBCCDD);
    mem2_valid = 1'b1; Data_MDR = 32'h112233C4;
    @(posedge clk); #1;
    mem2_valid = 1'b0;
    wait_out(to);
    e = exp_q.pop_front();
    checks++; if (to || Data_out !== e) begin failures++; $display("FAIL cross_half got=%h exp=%h", Data_out, e); end
    release_out();
  endtask

  task automatic test_hold();
    logic [31:0] e;
    exp_q.push_back(32'h12345678);
    issue(3'b001, 2'd0, 32'h12345678);
    e = exp_q.pop_front();
    req_valid = 1'b1; ls_ctrl = 3'b001; addr_off = 2'd0; Data_MDR = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || Data_out !== e || req_ready !== 1'b0) begin
        failures++; $display("FAIL hold_%0d valid=%b got=%h exp=%h req_ready=%b", i, out_valid, Data_out, e, req_ready);
      end
      @(posedge clk); #1;
    end
    release_out();
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL hold_release out_valid=%b req_ready=%b exp=0/1", out_valid, req_ready);
    end
    exp_q.push_back(32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || Data_out !== e) begin
      failures++; $display("FAIL hold_next valid=%b got=%h exp=%h", out_valid, Data_out, e);
    end
    release_out();
  endtask

  task automatic test_reset_wait2();
    logic [31:0] e;
    issue(3'b001, 2'd2, 32'h11111111);
    checks++; if (mem2_req !== 1'b1) begin failures++; $display("FAIL rst_wait2_enter mem2_req=%b exp=1", mem2_req); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem2_req !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL rst_wait2 mem2_req=%b out_valid=%b req_ready=%b exp=0/0/1", mem2_req, out_valid, req_ready);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'h000000AB);
    issue(3'b011, 2'd1, 32'h0000AB00);
    e = exp_q.pop_front();
    checks++; if (out_valid !== 1'b1 || Data_out !== e) begin
      failures++; $display("FAIL rst_after_load valid=%b got=%h exp=%h", out_valid, Data_out, e);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  c;
    logic [1:0]  o;
    logic [31:0] f, s, e;
    int          n;
    bit          to;
    for (int k = 0; k < 12; k++) begin
      c = 3'($urandom_range(1, 7));
      if (c[1:0] == 2'b00) c[1:0] = 2'b11;
      o = 2'($urandom);
      f = $urandom;
      s = $urandom;
      n = (c[1:0] == 2'b01) ? 4 : (c[1:0] == 2'b10) ? 2 : 1;
      exp_q.push_back(model(c, o, f, s));
      issue(c, o, f);
      if (int'(o) + n > 4) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        mem2_valid = 1'b1; Data_MDR = s;
        @(posedge clk); #1;
        mem2_valid = 1'b0;
      end
      wait_out(to);
      e = exp_q.pop_front();
      checks++; if (to || Data_out !== e) begin
        failures++; $display("FAIL b2b_%0d ctrl=%b off=%0d got=%h exp=%h", k, c, o, Data_out, e);
      end
      release_out();
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_misalign();
    test_cross();
    test_hold();
    test_reset_wait2();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
